// File: rtl/rssi_detect_fsm_if.sv
// rssi_detect_fsm_if
//   Bundles the comparator sample stream and the carrier-detect status
//   outputs of rssi_detect_fsm into one port.
//   Stream side (driven by master): enable, cmp_valid, cmp_res[2:0]
//   Status side (driven by slave):  detect, rise_pulse, fall_pulse,
//                                   state[1:0], err
//   master modport: the sample producer / control logic (testbench).
//   slave modport:  the detector itself.
interface rssi_detect_fsm_if;
  logic       enable;
  logic       cmp_valid;
  logic [2:0] cmp_res;
  logic       detect;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [1:0] state;
  logic       err;

  modport master (
    output enable, cmp_valid, cmp_res,
    input  detect, rise_pulse, fall_pulse, state, err
  );

  modport slave (
    input  enable, cmp_valid, cmp_res,
    output detect, rise_pulse, fall_pulse, state, err
  );
endinterface

// File: rtl/rssi_detect_fsm.sv
// rssi_detect_fsm
//   Debounces the per-sample threshold/RSSI comparison stream into a
//   stable carrier-detect flag. Separate acquire (ON_COUNT) and release
//   (OFF_COUNT) run lengths give hysteresis; rise/fall pulses mark the
//   first cycle of each new detect value.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - rssi_detect_fsm_if.slave: enable, cmp_valid, cmp_res in;
//            detect, rise_pulse, fall_pulse, state, err out
//   Build option:
//     RSSI_DET_ONEHOT_CHECK_EN - when defined, a valid non-one-hot
//     cmp_res sets the sticky err flag and parks the FSM in FAULT.
//     When undefined, illegal codes hold the count and err is tied 0.
module rssi_detect_fsm #(
  parameter int CNT_W     = 4,
  parameter int ON_COUNT  = 4,
  parameter int OFF_COUNT = 8
) (
  input  logic              clk,
  input  logic              rst,
  rssi_detect_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             detect_q;
  logic             rise_q;
  logic             fall_q;
  logic             err_q;

  logic             above;
  logic             below;
  logic [CNT_W-1:0] cnt_inc;

  // Sample classification; "equal" needs no decode since it simply holds.
  assign above   = bus.cmp_valid && (bus.cmp_res == 3'b001);
  assign below   = bus.cmp_valid && (bus.cmp_res == 3'b100);
  assign cnt_inc = cnt_q + 1'b1;

`ifdef RSSI_DET_ONEHOT_CHECK_EN
  logic illegal;
  assign illegal = bus.cmp_valid &&
                   (bus.cmp_res != 3'b001) &&
                   (bus.cmp_res != 3'b010) &&
                   (bus.cmp_res != 3'b100);
`endif

  // Whole detector: state, run counter and all registered outputs.
  // Priority is rst, then enable=0, then illegal sample, then counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      detect_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (!bus.enable) begin
        // Dropping enable releases a held carrier, so flag the edge.
        state_q  <= IDLE;
        cnt_q    <= '0;
        detect_q <= 1'b0;
        fall_q   <= detect_q;
      end else begin
        unique case (state_q)
          IDLE: begin
            // The sample coinciding with the enable rise is discarded.
            state_q <= ACQUIRE;
            cnt_q   <= '0;
          end
          ACQUIRE: begin
`ifdef RSSI_DET_ONEHOT_CHECK_EN
            if (illegal) begin
              state_q <= FAULT;
              err_q   <= 1'b1;
            end else
`endif
            if (above) begin
              if (cnt_inc == CNT_W'(ON_COUNT)) begin
                state_q  <= LOCKED;
                cnt_q    <= '0;
                detect_q <= 1'b1;
                rise_q   <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else if (below) begin
              cnt_q <= '0;
            end
          end
          LOCKED: begin
`ifdef RSSI_DET_ONEHOT_CHECK_EN
            if (illegal) begin
              state_q  <= FAULT;
              err_q    <= 1'b1;
              detect_q <= 1'b0;
              fall_q   <= 1'b1;
            end else
`endif
            if (below) begin
              if (cnt_inc == CNT_W'(OFF_COUNT)) begin
                state_q  <= ACQUIRE;
                cnt_q    <= '0;
                detect_q <= 1'b0;
                fall_q   <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else if (above) begin
              cnt_q <= '0;
            end
          end
          FAULT: begin
            // Frozen until enable drops or reset.
            state_q <= FAULT;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.detect     = detect_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
`ifdef RSSI_DET_ONEHOT_CHECK_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: doc/rssi_detect_fsm.md
# rssi_detect_fsm

Downstream consumer of the 6-bit magnitude comparator's 3-bit result (bit0 less-than, bit1 equal, bit2 greater-than; operand 1 is the internally generated threshold, operand 2 is the RSSI reading). This block debounces the per-sample comparison stream into a stable carrier-detect flag. It applies separate acquire and release run-lengths for hysteresis, and emits one-cycle edge pulses for the control logic.

## Interface
- CNT_W, 4: run-length counter width.
- ON_COUNT, 4: consecutive "above" samples required to assert detect; legal range 1..2^CNT_W-1.
- OFF_COUNT, 8: consecutive "below" samples required to drop detect; legal range 1..2^CNT_W-1.

- clk  in  1  Single clock; all state updates on rising edge.
- rst  in  1  Reset; synchronous, active-high.
- enable  in  1  Detector run enable; level-sensitive.
- cmp_valid  in  1  Strobe: cmp_res holds a new sample this cycle.
- cmp_res  in  3  Comparator result: [0] threshold<RSSI ("above"), [1] equal, [2] threshold>RSSI ("below").
- detect  out  1  Registered carrier-detect flag.
- rise_pulse  out  1  One-cycle pulse on detect 0->1.
- fall_pulse  out  1  One-cycle pulse on detect 1->0 (not on rst).
- state  out  2  Current FSM state: IDLE=0, ACQUIRE=1, LOCKED=2, FAULT=3.
- err  out  1  Sticky illegal-code flag; constant 0 when RSSI_DET_ONEHOT_CHECK_EN is undefined.

## Operation
- Sample classes (only when cmp_valid=1): above = 3'b001, below = 3'b100, equal = 3'b010. Any other code is illegal. cmp_valid=0 cycles are ignored (no count change).
- Equal samples and illegal samples (when the check is compiled out) hold the counter unchanged. They break neither run.
- IDLE: detect=0, cnt=0. enable=1 -> ACQUIRE.
- ACQUIRE: detect=0.
  - above: cnt+1; when the incremented value equals ON_COUNT -> LOCKED, cnt=0, detect=1, rise_pulse=1.
  - below: cnt=0.
- LOCKED: detect=1.
  - below: cnt+1; when it equals OFF_COUNT -> ACQUIRE, cnt=0, detect=0, fall_pulse=1.
  - above: cnt=0.
- enable=0 in any state -> IDLE on the next edge, cnt=0. If detect was 1, fall_pulse=1 that cycle. enable=0 takes priority over a simultaneous sample.
- FAULT (macro only): detect=0, counters frozen. Exits only via enable=0 (-> IDLE) or rst.
- Counter never exceeds max(ON_COUNT, OFF_COUNT), so there is no wrap.

## Timing
- Reset values: state=IDLE, cnt=0, detect=0, rise_pulse=0, fall_pulse=0, err=0.
- rst during any state (including LOCKED) returns to reset values on the next edge with no fall_pulse.
- Latency: the edge that samples the qualifying valid beat updates detect, state and the pulses. They are visible in the following cycle (1-cycle registered latency).
- Pulses are high for exactly one cycle and coincide with the first cycle of the new detect value.
- An enable rise is seen at the next edge (IDLE->ACQUIRE). A sample valid on that same cycle is ignored.
- Back-to-back valid every cycle is supported; there is no backpressure and no ready signal.

## Configuration
- RSSI_DET_ONEHOT_CHECK_EN defined:
  - A valid cycle with a non-one-hot cmp_res sets err=1 (sticky until rst) and forces state FAULT.
  - If the block was LOCKED, fall_pulse=1 and detect drops.
  - An illegal sample takes priority over counting.
- Undefined: illegal codes are treated as equal (hold), FAULT is unreachable, and err is tied 0.

## Test plan
- Reset and enable: rst=1 for 2 cycles, then enable=1 -> all outputs 0, state=1 one cycle after enable.
- Acquire with defaults: 4 consecutive valid 3'b001 -> detect=1 and rise_pulse=1 for one cycle after the 4th sample. Three above samples then one below -> detect stays 0, cnt cleared.
- Hysteresis release: from LOCKED, 7 below, 1 above, then 8 below -> detect stays 1 until after the final 8th below; fall_pulse for one cycle; state=1.
- Equal and gaps: in ACQUIRE, pattern above, equal, idle (cmp_valid=0), above, equal, above, above -> detect=1 after the 4th above (equal and idle cycles hold the count).
- Disable while locked: LOCKED, then enable=0 simultaneous with a below sample -> state=0, detect=0, fall_pulse=1. A mid-LOCKED rst instead gives fall_pulse=0.
- Macro on: valid cmp_res=3'b011 while LOCKED -> err=1, state=3, detect=0, fall_pulse=1. Subsequent above samples give no change. enable=0 -> state=0 with err still 1. Macro off: same stimulus gives a hold and err=0.
